// File: rtl/gato_tablero_param_if.sv
// rtl/gato_tablero_param_if.sv - button and board-status bundle for the tic-tac-toe board
// Purpose: groups the debounced button pulses (driven by the player side) and
//          the board/status outputs (driven by the board) into one port.
// Ports (signals):
//   boton_arriba/abajo/izq/der/elige  one-cycle button pulses into the board
//   cuadro     cursor cell index, row-major
//   tablero    2 bits per cell, 00 empty / 01 P1 / 10 P2
//   state      FSM state code
//   turno_p1_wire, turno_p2_wire, win_game_wire, loss_game_wire, tie_game_wire
//   linea_dir  direction of the winning line
// Modports: master = button source / status sink, slave = the board.
interface gato_tablero_param_if #(
    parameter int N = 3
);
    localparam int IDX_W = $clog2(N * N);

    logic                 boton_arriba;
    logic                 boton_abajo;
    logic                 boton_izq;
    logic                 boton_der;
    logic                 boton_elige;
    logic [IDX_W-1:0]     cuadro;
    logic [2*N*N-1:0]     tablero;
    logic [2:0]           state;
    logic                 turno_p1_wire;
    logic                 turno_p2_wire;
    logic                 win_game_wire;
    logic                 loss_game_wire;
    logic                 tie_game_wire;
    logic [1:0]           linea_dir;

    modport master (
        output boton_arriba, boton_abajo, boton_izq, boton_der, boton_elige,
        input  cuadro, tablero, state, turno_p1_wire, turno_p2_wire,
               win_game_wire, loss_game_wire, tie_game_wire, linea_dir
    );

    modport slave (
        input  boton_arriba, boton_abajo, boton_izq, boton_der, boton_elige,
        output cuadro, tablero, state, turno_p1_wire, turno_p2_wire,
               win_game_wire, loss_game_wire, tie_game_wire, linea_dir
    );
endinterface

// File: rtl/gato_tablero_param.sv
// rtl/gato_tablero_param.sv - N x N, K-in-a-row two-player board with cursor and line checker
// Purpose: cursor movement, mark placement, and a one-neighbour-per-cycle line
//          search after every placement that decides win / tie / next turn.
// Ports:
//   clk         rising-edge clock
//   reset_all   synchronous active-low full reset (highest priority)
//   reset_game  synchronous active-high new-game request
//   bus         gato_tablero_param_if.slave (buttons in, board/status out)
// Optional feature: define GATO_ALTERNA_INICIO_EN to alternate the starting
//   player on every reset_game (reset_all always makes P1 the starter).
module gato_tablero_param #(
    parameter int N = 3,
    parameter int K = 3,
    localparam int IDX_W = $clog2(N * N)
) (
    input  logic                 clk,
    input  logic                 reset_all,
    input  logic                 reset_game,
    gato_tablero_param_if.slave  bus
);
    localparam int CELLS  = N * N;
    localparam int MOV_W  = $clog2(CELLS + 1);
    localparam int RC_W   = $clog2(N);
    localparam int STEP_W = $clog2(K);
    localparam int CNT_W  = $clog2(K + 1);

    typedef enum logic [2:0] {
        TURN_P1 = 3'd0,
        TURN_P2 = 3'd1,
        CHECK   = 3'd2,
        WIN_P1  = 3'd3,
        WIN_P2  = 3'd4,
        TIE     = 3'd5
    } estado_t;

    estado_t            state_q, state_d;
    logic [2*CELLS-1:0] tablero_q, tablero_d;
    logic [RC_W-1:0]    fila_q, fila_d, col_q, col_d;
    logic [RC_W-1:0]    pfila_q, pfila_d, pcol_q, pcol_d;
    logic [MOV_W-1:0]   mov_q, mov_d;
    logic [1:0]         dir_q, dir_d, linea_q, linea_d;
    logic               lado_q, lado_d;      // 0: walking + side, 1: walking - side
    logic [STEP_W-1:0]  paso_q, paso_d;      // steps already taken on this side
    logic [CNT_W-1:0]   cuenta_q, cuenta_d;  // run length in the current direction
    logic               jug_q, jug_d;        // player being checked, 1 = P2
`ifdef GATO_ALTERNA_INICIO_EN
    logic               starter_q;           // 1 = current game started with P2
`endif

    // Padded to a power of two so any IDX_W-wide index reads a defined cell.
    logic [1:0]         celda [2**IDX_W];
    logic [IDX_W-1:0]   cur_idx, vec_idx;
    logic [1:0]         codigo, codigo_turno;
    logic               en_tablero, coincide, fin_lado;
    int                 dr, dc, paso, r, c;

    always_comb begin
        for (int i = 0; i < 2**IDX_W; i++) begin
            celda[i] = (i < CELLS) ? tablero_q[2*i +: 2] : 2'b00;
        end
        cur_idx      = IDX_W'(int'(fila_q) * N + int'(col_q));
        codigo       = jug_q ? 2'b10 : 2'b01;
        codigo_turno = (state_q == TURN_P2) ? 2'b10 : 2'b01;

        // Neighbour under examination: direction offset times step, sign by side.
        case (dir_q)
            2'd0:    begin dr = 0; dc = 1;  end
            2'd1:    begin dr = 1; dc = 0;  end
            2'd2:    begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        if (lado_q) begin
            dr = -dr;
            dc = -dc;
        end
        paso       = int'(paso_q) + 1;
        r          = int'(pfila_q) + dr * paso;
        c          = int'(pcol_q) + dc * paso;
        en_tablero = (r >= 0) && (r < N) && (c >= 0) && (c < N);
        vec_idx    = en_tablero ? IDX_W'(r * N + c) : '0;
        coincide   = en_tablero && (celda[vec_idx] == codigo);
    end

    always_comb begin
        state_d   = state_q;
        tablero_d = tablero_q;
        fila_d    = fila_q;
        col_d     = col_q;
        pfila_d   = pfila_q;
        pcol_d    = pcol_q;
        mov_d     = mov_q;
        dir_d     = dir_q;
        linea_d   = linea_q;
        lado_d    = lado_q;
        paso_d    = paso_q;
        cuenta_d  = cuenta_q;
        jug_d     = jug_q;
        fin_lado  = 1'b0;

        case (state_q)
            TURN_P1, TURN_P2: begin
                if (bus.boton_elige) begin
                    if (celda[cur_idx] == 2'b00) begin
                        tablero_d[2*int'(cur_idx) +: 2] = codigo_turno;
                        mov_d    = mov_q + MOV_W'(1);
                        pfila_d  = fila_q;
                        pcol_d   = col_q;
                        jug_d    = (state_q == TURN_P2);
                        dir_d    = 2'd0;
                        lado_d   = 1'b0;
                        paso_d   = '0;
                        cuenta_d = CNT_W'(1);
                        state_d  = CHECK;
                    end
                end else if (bus.boton_arriba) begin
                    fila_d = (fila_q == '0) ? RC_W'(N - 1) : fila_q - RC_W'(1);
                end else if (bus.boton_abajo) begin
                    fila_d = (fila_q == RC_W'(N - 1)) ? '0 : fila_q + RC_W'(1);
                end else if (bus.boton_izq) begin
                    col_d = (col_q == '0) ? RC_W'(N - 1) : col_q - RC_W'(1);
                end else if (bus.boton_der) begin
                    col_d = (col_q == RC_W'(N - 1)) ? '0 : col_q + RC_W'(1);
                end
            end

            CHECK: begin
                if (coincide) begin
                    if (int'(cuenta_q) + 1 == K) begin
                        state_d = jug_q ? WIN_P2 : WIN_P1;
                        linea_d = dir_q;
                    end else begin
                        cuenta_d = cuenta_q + CNT_W'(1);
                        if (paso == K - 1) fin_lado = 1'b1;
                        else               paso_d   = paso_q + STEP_W'(1);
                    end
                end else begin
                    fin_lado = 1'b1;
                end

                if (fin_lado) begin
                    if (!lado_q) begin
                        lado_d = 1'b1;
                        paso_d = '0;
                    end else if (dir_q == 2'd3) begin
                        if (mov_q == MOV_W'(CELLS)) state_d = TIE;
                        else                        state_d = jug_q ? TURN_P1 : TURN_P2;
                    end else begin
                        dir_d    = dir_q + 2'd1;
                        lado_d   = 1'b0;
                        paso_d   = '0;
                        cuenta_d = CNT_W'(1);
                    end
                end
            end

            WIN_P1, WIN_P2, TIE: state_d = state_q;

            default: state_d = TURN_P1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_all || reset_game) begin
            tablero_q <= '0;
            fila_q    <= '0;
            col_q     <= '0;
            pfila_q   <= '0;
            pcol_q    <= '0;
            mov_q     <= '0;
            dir_q     <= '0;
            linea_q   <= '0;
            lado_q    <= 1'b0;
            paso_q    <= '0;
            cuenta_q  <= CNT_W'(1);
            jug_q     <= 1'b0;
`ifdef GATO_ALTERNA_INICIO_EN
            if (!reset_all) begin
                starter_q <= 1'b0;
                state_q   <= TURN_P1;
            end else begin
                starter_q <= ~starter_q;
                state_q   <= starter_q ? TURN_P1 : TURN_P2;
            end
`else
            state_q   <= TURN_P1;
`endif
        end else begin
            state_q   <= state_d;
            tablero_q <= tablero_d;
            fila_q    <= fila_d;
            col_q     <= col_d;
            pfila_q   <= pfila_d;
            pcol_q    <= pcol_d;
            mov_q     <= mov_d;
            dir_q     <= dir_d;
            linea_q   <= linea_d;
            lado_q    <= lado_d;
            paso_q    <= paso_d;
            cuenta_q  <= cuenta_d;
            jug_q     <= jug_d;
        end
    end

    assign bus.cuadro         = cur_idx;
    assign bus.tablero        = tablero_q;
    assign bus.state          = state_q;
    assign bus.turno_p1_wire  = (state_q == TURN_P1);
    assign bus.turno_p2_wire  = (state_q == TURN_P2);
    assign bus.loss_game_wire = (state_q == WIN_P1);
    assign bus.win_game_wire  = (state_q == WIN_P2);
    assign bus.tie_game_wire  = (state_q == TIE);
    assign bus.linea_dir      = linea_q;
endmodule

// File: tb/tb_gato_tablero_param.sv
// tb/tb_gato_tablero_param.sv - randomized and directed self-checking bench for gato_tablero_param
module tb_gato_tablero_param;
    localparam int N  = 3;
    localparam int K  = 3;
    localparam int N5 = 5;
    localparam int K5 = 4;

    logic clk = 1'b0;
    logic reset_all = 1'b1;
    logic reset_game = 1'b0;

    gato_tablero_param_if #(.N(N))  bus3 ();
    gato_tablero_param_if #(.N(N5)) bus5 ();

    gato_tablero_param #(.N(N), .K(K)) dut3 (
        .clk(clk), .reset_all(reset_all), .reset_game(reset_game), .bus(bus3)
    );
    gato_tablero_param #(.N(N5), .K(K5)) dut5 (
        .clk(clk), .reset_all(reset_all), .reset_game(reset_game), .bus(bus5)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the 3x3 game
    int mb [N*N];
    int mfila, mcol, mmov, mstate, mlinea, mstarter;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_tab();
        logic [63:0] v = '0;
        for (int i = 0; i < N*N; i++) v[2*i +: 2] = 2'(mb[i]);
        return v;
    endfunction

    // First direction (in 0..3 order) whose line through (r0,c0) holds K marks of p.
    function automatic int model_win(input int p, input int r0, input int c0);
        int drs [4] = '{0, 1, 1, 1};
        int dcs [4] = '{1, 0, 1, -1};
        for (int d = 0; d < 4; d++) begin
            int cnt = 1;
            for (int s = 1; s >= -1; s -= 2) begin
                for (int k = 1; k < K; k++) begin
                    int r = r0 + s * drs[d] * k;
                    int c = c0 + s * dcs[d] * k;
                    if (r < 0 || r >= N || c < 0 || c >= N) break;
                    if (mb[r*N + c] != p) break;
                    cnt++;
                end
            end
            if (cnt >= K) return d;
        end
        return -1;
    endfunction

    task automatic compare_all(input string tag);
        check_eq({tag, ".cuadro"},  64'(bus3.cuadro), 64'(mfila*N + mcol));
        check_eq({tag, ".tablero"}, 64'(bus3.tablero), exp_tab());
        check_eq({tag, ".state"},   64'(bus3.state), 64'(mstate));
        check_eq({tag, ".status"},
                 64'({bus3.turno_p1_wire, bus3.turno_p2_wire, bus3.loss_game_wire,
                      bus3.win_game_wire, bus3.tie_game_wire}),
                 64'({mstate == 0, mstate == 1, mstate == 3, mstate == 4, mstate == 5}));
        check_eq({tag, ".linea"},   64'(bus3.linea_dir), 64'(mlinea));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N*N; i++) mb[i] = 0;
        mfila = 0; mcol = 0; mmov = 0; mlinea = 0;
    endtask

    task automatic do_reset_all();
        reset_all = 1'b0;
        tick();
        reset_all = 1'b1;
        model_clear();
        mstarter = 0;
        mstate = 0;
        compare_all("reset_all");
    endtask

    task automatic do_reset_game();
        reset_game = 1'b1;
        tick();
        reset_game = 1'b0;
        model_clear();
`ifdef GATO_ALTERNA_INICIO_EN
        mstarter = 1 - mstarter;
`endif
        mstate = mstarter;
        compare_all("reset_game");
    endtask

    // m = {elige, arriba, abajo, izq, der}
    task automatic press(input logic [4:0] m, input bit wait_chk);
        bit placed = 0;
        int player = 0, pr = 0, pc = 0, w, cnt;
        if (mstate <= 1) begin
            if (m[4]) begin
                if (mb[mfila*N + mcol] == 0) begin
                    player = mstate;
                    pr = mfila; pc = mcol;
                    mb[mfila*N + mcol] = player + 1;
                    mmov++;
                    mstate = 2;
                    placed = 1;
                end
            end else if (m[3]) mfila = (mfila + N - 1) % N;
            else if (m[2]) mfila = (mfila + 1) % N;
            else if (m[1]) mcol = (mcol + N - 1) % N;
            else if (m[0]) mcol = (mcol + 1) % N;
        end
        {bus3.boton_elige, bus3.boton_arriba, bus3.boton_abajo, bus3.boton_izq, bus3.boton_der} = m;
        tick();
        {bus3.boton_elige, bus3.boton_arriba, bus3.boton_abajo, bus3.boton_izq, bus3.boton_der} = '0;
        compare_all("press");
        if (placed && wait_chk) begin
            cnt = 0;
            while (bus3.state == 3'd2 && cnt <= 8*(K-1)) begin
                tick();
                cnt++;
            end
            check_eq("check_len", 64'(cnt <= 8*(K-1)), 64'd1);
            w = model_win(player + 1, pr, pc);
            if (w >= 0) begin
                mstate = player ? 4 : 3;
                mlinea = w;
            end else begin
                mstate = (mmov == N*N) ? 5 : 1 - player;
            end
            compare_all("after_check");
        end
    endtask

    task automatic play_cell(input int idx);
        while (mcol != idx % N) press(5'b00001, 1'b1);
        while (mfila != idx / N) press(5'b00100, 1'b1);
        press(5'b10000, 1'b1);
    endtask

    task automatic pulse5(input logic [4:0] m);
        {bus5.boton_elige, bus5.boton_arriba, bus5.boton_abajo, bus5.boton_izq, bus5.boton_der} = m;
        tick();
        {bus5.boton_elige, bus5.boton_arriba, bus5.boton_abajo, bus5.boton_izq, bus5.boton_der} = '0;
    endtask

    initial begin
        int cnt;
        int seq_win1 [5] = '{0, 3, 1, 4, 2};
        int seq_win2 [6] = '{0, 2, 1, 4, 3, 6};
        int seq_tie  [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        {bus3.boton_elige, bus3.boton_arriba, bus3.boton_abajo, bus3.boton_izq, bus3.boton_der} = '0;
        {bus5.boton_elige, bus5.boton_arriba, bus5.boton_abajo, bus5.boton_izq, bus5.boton_der} = '0;
        tick();
        do_reset_all();

        // 5x5, K=4 cursor wrap and occupied-cell behaviour
        check_eq("n5.reset_cuadro", 64'(bus5.cuadro), 64'd0);
        pulse5(5'b00010);
        check_eq("n5.izq_wrap", 64'(bus5.cuadro), 64'd4);
        pulse5(5'b01000);
        check_eq("n5.arriba_wrap", 64'(bus5.cuadro), 64'd24);
        pulse5(5'b10000);
        check_eq("n5.enter_check", 64'(bus5.state), 64'd2);
        cnt = 0;
        while (bus5.state == 3'd2 && cnt <= 8*(K5-1)) begin
            tick();
            cnt++;
        end
        check_eq("n5.check_len", 64'(cnt <= 8*(K5-1)), 64'd1);
        check_eq("n5.turn_p2", 64'(bus5.state), 64'd1);
        pulse5(5'b10000);
        check_eq("n5.occupied_state", 64'(bus5.state), 64'd1);
        check_eq("n5.tablero", 64'(bus5.tablero), 64'h1 << 48);

        // P1 row 0 win
        do_reset_all();
        foreach (seq_win1[i]) play_cell(seq_win1[i]);
        check_eq("win1.state", 64'(bus3.state), 64'd3);
        check_eq("win1.loss", 64'(bus3.loss_game_wire), 64'd1);
        check_eq("win1.linea", 64'(bus3.linea_dir), 64'd0);
        check_eq("win1.row0", 64'(bus3.tablero[5:0]), 64'b010101);

        // P2 anti-diagonal win, then buttons ignored
        do_reset_all();
        foreach (seq_win2[i]) play_cell(seq_win2[i]);
        check_eq("win2.win", 64'(bus3.win_game_wire), 64'd1);
        check_eq("win2.linea", 64'(bus3.linea_dir), 64'd3);
        press(5'b10000, 1'b1);
        press(5'b00010, 1'b1);
        press(5'b01000, 1'b1);

        // Full board, no line
        do_reset_all();
        foreach (seq_tie[i]) play_cell(seq_tie[i]);
        check_eq("tie.wire", 64'(bus3.tie_game_wire), 64'd1);
        check_eq("tie.moves", 64'(mmov), 64'd9);

        // reset_game during CHECK, and reset_all beating elige
        do_reset_game();
        press(5'b10000, 1'b0);
        check_eq("abort.in_check", 64'(bus3.state), 64'd2);
        do_reset_game();
        do_reset_game();
        {bus3.boton_elige, bus3.boton_arriba, bus3.boton_abajo, bus3.boton_izq, bus3.boton_der} = 5'b10000;
        reset_all = 1'b0;
        tick();
        reset_all = 1'b1;
        {bus3.boton_elige, bus3.boton_arriba, bus3.boton_abajo, bus3.boton_izq, bus3.boton_der} = '0;
        model_clear();
        mstarter = 0;
        mstate = 0;
        compare_all("reset_all_vs_elige");

        // Randomized games
        for (int g = 0; g < 12; g++) begin
            for (int s = 0; s < 120 && mstate <= 1; s++) begin
                logic [4:0] m;
                if ($urandom_range(0, 3) == 0) m = 5'b10000;
                else                           m = 5'($urandom_range(0, 31));
                press(m, 1'b1);
            end
            for (int s = 0; s < 3; s++) press(5'($urandom_range(0, 31)), 1'b1);
            if ($urandom_range(0, 1) == 0) do_reset_game();
            else                           do_reset_all();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/gato_tablero_param.md
GATO_TABLERO_PARAM -- requirements
Module: gato_tablero_param

Interface
REQ-001 Parameter N, default 3: board side; legal 3..8.
REQ-002 Parameter K, default 3: marks in a row needed to win; legal 3..N.
REQ-003 Derived IDX_W = clog2(N*N): cell index width.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset_all  in  1  synchronous, active-low full reset.
REQ-006 reset_game  in  1  synchronous, active-high new-game request.
REQ-007 boton_arriba, boton_abajo, boton_izq, boton_der, boton_elige  in  1 each  debounced one-cycle pulses: cursor up/down/left/right, place mark.
REQ-008 cuadro  out  IDX_W  cursor cell index, row-major, 0 = top-left.
REQ-009 tablero  out  2*N*N  board; cell i at bits [2i+1:2i]; 00 empty, 01 P1, 10 P2.
REQ-010 state  out  3  FSM state encoding (REQ-014).
REQ-011 turno_p1_wire, turno_p2_wire  out  1 each  high in the matching TURN state.
REQ-012 win_game_wire (P2 won), loss_game_wire (P1 won), tie_game_wire  out  1 each  high in the matching terminal state.
REQ-013 linea_dir  out  2  winning direction: 00 horizontal, 01 vertical, 10 diagonal down-right, 11 diagonal down-left; 00 when no win.

Function
REQ-014 States: TURN_P1=0, TURN_P2=1, CHECK=2, WIN_P1=3, WIN_P2=4, TIE=5; codes 6-7 go to TURN_P1 on the next cycle.
REQ-015 Cursor moves only in TURN states, one cell per pulse, wrapping within its row (left/right) or column (up/down).
REQ-016 Per-cycle button priority: elige > arriba > abajo > izq > der; exactly one action per cycle; lower-priority pulses are dropped.
REQ-017 elige on an empty cell writes the current player's code next cycle, increments move count (0..N*N), latches the cell index, and enters CHECK.
REQ-018 elige on an occupied cell is ignored: no write, no state change.
REQ-019 CHECK examines one neighbour per cycle: for each direction in linea_dir order, walk the + side then the - side from the placed cell, up to K-1 steps per side; a side ends on out-of-bounds, a non-matching cell, or K-1 matches.
REQ-020 A run counter starts at 1 per direction; when it reaches K, leave CHECK next cycle to WIN_P1/WIN_P2 with linea_dir set to that direction.
REQ-021 No run reaches K and move count = N*N -> TIE; otherwise -> the other player's TURN state.
REQ-022 CHECK lasts at most 8*(K-1) cycles.
REQ-023 All buttons are ignored in CHECK and terminal states; terminal states hold until reset_game or reset_all.
REQ-024 Board bounds: no wrap in CHECK; column index stays in 0..N-1 and row index in 0..N-1.

Reset
REQ-025 reset_all low (sampled at a clock edge) -> next cycle: board all 00, cuadro 0, move count 0, linea_dir 00, state TURN_P1, all status outputs low except turno_p1_wire.
REQ-026 reset_game high -> same as REQ-025 from any state, including mid-CHECK (check aborted), except the starting player per REQ-029.
REQ-027 reset_all low takes priority over reset_game and over any button in the same cycle.

Configuration
REQ-028 Macro GATO_ALTERNA_INICIO_EN selects the starting player of each new game.
REQ-029 Defined: each reset_game toggles the starter (TURN_P1 <-> TURN_P2); reset_all restores P1 as starter. Undefined: every game starts in TURN_P1, and the starter register is not implemented.

Verification
REQ-030 N=3,K=3: P1 plays 0,1,2; P2 plays 3,4 -> after the 3rd P1 move, CHECK then WIN_P1; loss_game_wire=1, linea_dir=00, tablero[5:0]=010101.
REQ-031 N=3,K=3: P2 completes 2,4,6 -> win_game_wire=1, linea_dir=11; later elige/cursor pulses leave tablero unchanged.
REQ-032 N=3,K=3: full board with no line -> tie_game_wire=1 after the 9th move; move count = 9.
REQ-033 N=5,K=4: cursor at 0, boton_izq -> cuadro=4; boton_arriba -> cuadro=24; elige on an occupied cell -> state unchanged.
REQ-034 reset_game pulsed during CHECK -> next cycle tablero=0, state=TURN_P1 (macro off) or the toggled starter (macro on); reset_all low with elige in the same cycle -> board stays empty.
